// File: rtl/banked_regfile_mp_if.sv
// Bus bundle for the banked register file: mode/bank select, read ports, two write ports and status.
interface banked_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 3
);
    logic [4:0]               mode;
    logic                     user_bank;
    logic [4*NUM_RD-1:0]      rd_addr;
    logic [DATA_W*NUM_RD-1:0] rd_data;
    logic                     wr0_en;
    logic [3:0]               wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [3:0]               wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     ready;
    logic                     mode_err;

    modport master (
        output mode, user_bank, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data,
        input  rd_data, ready, mode_err
    );

    modport slave (
        input  mode, user_bank, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data,
        output rd_data, ready, mode_err
    );
endinterface

// File: rtl/banked_regfile_mp.sv
// ARM7TDMI banked register file: 16 architectural registers mapped onto 31 physical
// registers by mode, registered multi-port reads, dual write, and a post-reset clear walk.
//
// state   | meaning
// S_CLEAR | walking P0..P30 writing zero; writes ignored, reads return 0
// S_RUN   | normal operation, ready=1
module banked_regfile_mp #(
    parameter int DATA_W         = 32,
    parameter int NUM_RD         = 3,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic               clk,
    input logic               reset,
    banked_regfile_mp_if.slave bus
);
    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                         state_q, state_d;
    logic [4:0]                     cnt_q, cnt_d;
    logic [DATA_W-1:0]              regs_q [31];
    logic [DATA_W-1:0]              regs_d [31];
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;
    logic                           mode_err_q, mode_err_d;

    logic [4:0] wr0_phys, wr1_phys, rd_phys;
    logic       wr0_go, wr1_go;

    function automatic logic mode_legal(input logic [4:0] m);
        case (m)
            M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Illegal modes fall through to the USR map; r13/r14 banks pick P(base) for r13, P(base+1) for r14.
    function automatic logic [4:0] phys_idx(input logic [4:0] m, input logic ub,
                                            input logic [3:0] a);
        logic [4:0] p;
        logic       r13_14;
        p      = {1'b0, a};
        r13_14 = (a == 4'd13) || (a == 4'd14);
        if (!ub) begin
            case (m)
                M_FIQ: if (a >= 4'd8 && a <= 4'd14) p = {1'b0, a} + 5'd8;
                M_SVC: if (r13_14) p = 5'd23 + {4'd0, ~a[0]};
                M_ABT: if (r13_14) p = 5'd25 + {4'd0, ~a[0]};
                M_IRQ: if (r13_14) p = 5'd27 + {4'd0, ~a[0]};
                M_UND: if (r13_14) p = 5'd29 + {4'd0, ~a[0]};
                default: p = {1'b0, a};
            endcase
        end
        return p;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regs_d     = regs_q;
        rd_data_d  = '0;
        rd_phys    = '0;
        mode_err_d = ~mode_legal(bus.mode);
        wr0_phys   = phys_idx(bus.mode, bus.user_bank, bus.wr0_addr);
        wr1_phys   = phys_idx(bus.mode, bus.user_bank, bus.wr1_addr);
        wr0_go     = (state_q == S_RUN) && bus.wr0_en;
        wr1_go     = (state_q == S_RUN) && bus.wr1_en;

        case (state_q)
            S_CLEAR: begin
                if (CLEAR_ON_RESET) begin
                    regs_d[cnt_q] = '0;
                    if (cnt_q == 5'd30) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // wr1 assigned last so it wins on a shared physical target
                if (wr0_go) regs_d[wr0_phys] = bus.wr0_data;
                if (wr1_go) regs_d[wr1_phys] = bus.wr1_data;
            end
        endcase

        for (int k = 0; k < NUM_RD; k++) begin
            rd_phys = phys_idx(bus.mode, bus.user_bank, bus.rd_addr[4*k +: 4]);
            if (state_q == S_RUN) begin
                rd_data_d[k] = regs_q[rd_phys];
                if (BYPASS) begin
                    if (wr0_go && wr0_phys == rd_phys) rd_data_d[k] = bus.wr0_data;
                    if (wr1_go && wr1_phys == rd_phys) rd_data_d[k] = bus.wr1_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            mode_err_q <= mode_err_d;
            regs_q     <= regs_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.ready    = (state_q == S_RUN);
    assign bus.mode_err = mode_err_q;
endmodule

// File: tb/tb_banked_regfile_mp.sv
// Directed bench for banked_regfile_mp: two instances (bypass on / off) driven identically.
module tb_banked_regfile_mp;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    banked_regfile_mp_if #(.DATA_W(DW), .NUM_RD(NR)) ifa ();
    banked_regfile_mp_if #(.DATA_W(DW), .NUM_RD(NR)) ifb ();

    banked_regfile_mp #(.DATA_W(DW), .NUM_RD(NR), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    banked_regfile_mp #(.DATA_W(DW), .NUM_RD(NR), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    function automatic logic [31:0] rd_a(input int k);
        return ifa.rd_data[32*k +: 32];
    endfunction

    function automatic logic [31:0] rd_b(input int k);
        return ifb.rd_data[32*k +: 32];
    endfunction

    task automatic drive(input logic [4:0] m, input logic ub, input logic [11:0] ra,
                         input logic w0e, input logic [3:0] w0a, input logic [31:0] w0d,
                         input logic w1e, input logic [3:0] w1a, input logic [31:0] w1d);
        ifa.mode = m; ifa.user_bank = ub; ifa.rd_addr = ra;
        ifa.wr0_en = w0e; ifa.wr0_addr = w0a; ifa.wr0_data = w0d;
        ifa.wr1_en = w1e; ifa.wr1_addr = w1a; ifa.wr1_data = w1d;
        ifb.mode = m; ifb.user_bank = ub; ifb.rd_addr = ra;
        ifb.wr0_en = w0e; ifb.wr0_addr = w0a; ifb.wr0_data = w0d;
        ifb.wr1_en = w1e; ifb.wr1_addr = w1a; ifb.wr1_data = w1d;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(M_USR, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic rd1(input logic [4:0] m, input logic ub, input logic [3:0] a,
                       output logic [31:0] da, output logic [31:0] db);
        drive(m, ub, {3{a}}, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        da = rd_a(0);
        db = rd_b(0);
        idle();
    endtask

    task automatic wr(input logic [4:0] m, input logic ub, input logic [3:0] a,
                      input logic [31:0] d);
        drive(m, ub, 12'h0, 1'b1, a, d, 1'b0, 4'd0, 32'h0);
        step();
        idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ifa.ready !== 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        logic [31:0] da, db;
        int n;
        logic [4:0] bm [4];
        bm[0] = M_SVC; bm[1] = M_ABT; bm[2] = M_IRQ; bm[3] = M_UND;
        reset = 1'b1;
        idle();
        step();
        step();
        checks++;
        if (ifa.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ifa.ready); end
        checks++;
        if (ifa.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", ifa.rd_data); end
        checks++;
        if (ifa.mode_err !== 1'b0) begin errors++; $display("FAIL reset_mode_err: got %b expected 0", ifa.mode_err); end
        reset = 1'b0;
        wait_ready(n);
        checks++;
        if (n != 31) begin errors++; $display("FAIL clear_len: got %0d expected 31", n); end
        checks++;
        if (ifb.ready !== 1'b1) begin errors++; $display("FAIL clear_ready_b: got %b expected 1", ifb.ready); end
        for (int r = 0; r < 16; r++) begin
            rd1(M_USR, 1'b0, 4'(r), da, db);
            checks++;
            if (da !== 32'h0) begin errors++; $display("FAIL clr_usr r%0d: got %h expected 0", r, da); end
        end
        for (int r = 8; r < 15; r++) begin
            rd1(M_FIQ, 1'b0, 4'(r), da, db);
            checks++;
            if (da !== 32'h0) begin errors++; $display("FAIL clr_fiq r%0d: got %h expected 0", r, da); end
        end
        for (int b = 0; b < 4; b++) begin
            for (int r = 13; r < 15; r++) begin
                rd1(bm[b], 1'b0, 4'(r), da, db);
                checks++;
                if (da !== 32'h0) begin errors++; $display("FAIL clr_bank m%b r%0d: got %h expected 0", bm[b], r, da); end
            end
        end
    endtask

    task automatic test_banking();
        logic [31:0] da, db;
        wr(M_USR, 1'b0, 4'd13, 32'h11111111);
        wr(M_SVC, 1'b0, 4'd13, 32'h22222222);
        wr(M_FIQ, 1'b0, 4'd8,  32'h33333333);
        rd1(M_USR, 1'b0, 4'd13, da, db);
        checks++;
        if (da !== 32'h11111111) begin errors++; $display("FAIL usr_r13: got %h expected 11111111", da); end
        rd1(M_SVC, 1'b0, 4'd13, da, db);
        checks++;
        if (da !== 32'h22222222) begin errors++; $display("FAIL svc_r13: got %h expected 22222222", da); end
        rd1(M_FIQ, 1'b0, 4'd8, da, db);
        checks++;
        if (da !== 32'h33333333) begin errors++; $display("FAIL fiq_r8: got %h expected 33333333", da); end
        rd1(M_USR, 1'b0, 4'd8, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL usr_r8: got %h expected 0", da); end
        rd1(M_IRQ, 1'b0, 4'd13, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL irq_r13: got %h expected 0", da); end
        rd1(M_SYS, 1'b0, 4'd13, da, db);
        checks++;
        if (da !== 32'h11111111) begin errors++; $display("FAIL sys_r13: got %h expected 11111111", da); end
        // independent ports: port0=r13, port1=r8, port2=r15 in FIQ
        drive(M_FIQ, 1'b0, {4'd15, 4'd8, 4'd13}, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        checks++;
        if (rd_a(0) !== 32'h0) begin errors++; $display("FAIL mp_fiq_r13: got %h expected 0", rd_a(0)); end
        checks++;
        if (rd_a(1) !== 32'h33333333) begin errors++; $display("FAIL mp_fiq_r8: got %h expected 33333333", rd_a(1)); end
        checks++;
        if (rd_a(2) !== 32'h0) begin errors++; $display("FAIL mp_r15: got %h expected 0", rd_a(2)); end
        idle();
    endtask

    task automatic test_user_bank();
        logic [31:0] da, db;
        wr(M_SVC, 1'b1, 4'd14, 32'hCAFEF00D);
        rd1(M_USR, 1'b0, 4'd14, da, db);
        checks++;
        if (da !== 32'hCAFEF00D) begin errors++; $display("FAIL ub_usr_r14: got %h expected cafef00d", da); end
        rd1(M_SVC, 1'b0, 4'd14, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL ub_svc_r14: got %h expected 0", da); end
        rd1(M_SVC, 1'b1, 4'd14, da, db);
        checks++;
        if (da !== 32'hCAFEF00D) begin errors++; $display("FAIL ub_read_r14: got %h expected cafef00d", da); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] da, db;
        wr(M_USR, 1'b0, 4'd5, 32'h1234);
        drive(M_USR, 1'b0, {3{4'd5}}, 1'b1, 4'd5, 32'hAAAA, 1'b1, 4'd5, 32'hBBBB);
        step();
        checks++;
        if (rd_a(0) !== 32'hBBBB) begin errors++; $display("FAIL byp_on: got %h expected 0000bbbb", rd_a(0)); end
        checks++;
        if (rd_b(0) !== 32'h1234) begin errors++; $display("FAIL byp_off: got %h expected 00001234", rd_b(0)); end
        idle();
        rd1(M_USR, 1'b0, 4'd5, da, db);
        checks++;
        if (da !== 32'hBBBB) begin errors++; $display("FAIL r5_a: got %h expected 0000bbbb", da); end
        checks++;
        if (db !== 32'hBBBB) begin errors++; $display("FAIL r5_b: got %h expected 0000bbbb", db); end
        // distinct targets, both commit; port0=r1, port1=r2
        drive(M_USR, 1'b0, {4'd0, 4'd2, 4'd1}, 1'b1, 4'd1, 32'h10, 1'b1, 4'd2, 32'h20);
        step();
        checks++;
        if (rd_a(0) !== 32'h10) begin errors++; $display("FAIL dual_byp_r1: got %h expected 10", rd_a(0)); end
        checks++;
        if (rd_a(1) !== 32'h20) begin errors++; $display("FAIL dual_byp_r2: got %h expected 20", rd_a(1)); end
        checks++;
        if (rd_b(0) !== 32'h0) begin errors++; $display("FAIL dual_old_r1: got %h expected 0", rd_b(0)); end
        checks++;
        if (rd_b(1) !== 32'h0) begin errors++; $display("FAIL dual_old_r2: got %h expected 0", rd_b(1)); end
        drive(M_USR, 1'b0, {4'd0, 4'd2, 4'd1}, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        checks++;
        if (rd_b(0) !== 32'h10) begin errors++; $display("FAIL dual_st_r1: got %h expected 10", rd_b(0)); end
        checks++;
        if (rd_b(1) !== 32'h20) begin errors++; $display("FAIL dual_st_r2: got %h expected 20", rd_b(1)); end
        idle();
    endtask

    task automatic test_mode_err();
        logic [31:0] da, db;
        step();
        checks++;
        if (ifa.mode_err !== 1'b0) begin errors++; $display("FAIL merr_pre: got %b expected 0", ifa.mode_err); end
        drive(5'b10100, 1'b0, {3{4'd13}}, 1'b1, 4'd13, 32'h5, 1'b0, 4'd0, 32'h0);
        step();
        checks++;
        if (ifa.mode_err !== 1'b1) begin errors++; $display("FAIL merr_set: got %b expected 1", ifa.mode_err); end
        checks++;
        if (rd_a(0) !== 32'h5) begin errors++; $display("FAIL merr_byp: got %h expected 5", rd_a(0)); end
        idle();
        rd1(M_USR, 1'b0, 4'd13, da, db);
        checks++;
        if (da !== 32'h5) begin errors++; $display("FAIL merr_usr_r13: got %h expected 5", da); end
        checks++;
        if (ifa.mode_err !== 1'b0) begin errors++; $display("FAIL merr_clr: got %b expected 0", ifa.mode_err); end
    endtask

    task automatic test_clear_restart();
        logic [31:0] da, db;
        int n;
        reset = 1'b1;
        drive(M_USR, 1'b0, {3{4'd5}}, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        reset = 1'b0;
        step();
        // r5 still holds bbbb physically here, but CLEAR must mask it
        checks++;
        if (rd_a(0) !== 32'h0) begin errors++; $display("FAIL clr_read: got %h expected 0", rd_a(0)); end
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        while (ifa.ready !== 1'b1 && n < 100) begin
            n++;
            if (n == 16) drive(M_USR, 1'b0, 12'h0, 1'b1, 4'd7, 32'hDEAD, 1'b1, 4'd9, 32'hBEEF);
            else idle();
            step();
        end
        idle();
        checks++;
        if (n != 31) begin errors++; $display("FAIL restart_len: got %0d expected 31", n); end
        rd1(M_USR, 1'b0, 4'd7, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL clr_wr_r7: got %h expected 0", da); end
        rd1(M_USR, 1'b0, 4'd9, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL clr_wr_r9: got %h expected 0", da); end
        rd1(M_USR, 1'b0, 4'd5, da, db);
        checks++;
        if (da !== 32'h0) begin errors++; $display("FAIL reclr_r5_a: got %h expected 0", da); end
        checks++;
        if (db !== 32'h0) begin errors++; $display("FAIL reclr_r5_b: got %h expected 0", db); end
    endtask

    initial begin
        test_reset();
        test_banking();
        test_user_bank();
        test_back_to_back();
        test_mode_err();
        test_clear_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banked_regfile_mp.md
Name: banked_regfile_mp

Overview:
Parametrised ARM7TDMI banked register file for the GBA core. It has NUM_RD registered read ports and two write ports (Rd and RdHi). All accesses use a single posedge clock. It maps the 16 architectural registers onto 31 physical registers according to processor mode, with an optional user-bank override for LDM/STM with the S bit. Also provided: same-cycle write-to-read bypass, a reset-time clear sequencer with a ready flag, and invalid-mode detection. It sits between decode and the execute/writeback datapath.

Parameters:
DATA_W, 32, width of every register and data port
NUM_RD, 3, number of independent read ports (at least 1)
BYPASS, 1, 1 = a read of a register written in the same cycle returns the new data; 0 = it returns the old data
CLEAR_ON_RESET, 1, 1 = after reset, walk all 31 physical registers and write 0; 0 = contents are undefined after reset

Ports:
clk  in  1  core clock, all logic on posedge
reset  in  1  synchronous, active-high reset
mode  in  5  CPSR mode bits: 10000 USR, 10001 FIQ, 10010 IRQ, 10011 SVC, 10111 ABT, 11011 UND, 11111 SYS
user_bank  in  1  when 1, all reads and writes use the USR mapping regardless of mode
rd_addr  in  4*NUM_RD  read register indices; port k uses bits [4k+3:4k]
rd_data  out  DATA_W*NUM_RD  registered read data; port k uses slice k
wr0_en  in  1  write enable, port 0 (Rd)
wr0_addr  in  4  write index, port 0
wr0_data  in  DATA_W  write data, port 0
wr1_en  in  1  write enable, port 1 (RdHi)
wr1_addr  in  4  write index, port 1
wr1_data  in  DATA_W  write data, port 1
ready  out  1  high when the block accepts writes and reads return stored data
mode_err  out  1  registered; high when the mode sampled on the previous cycle was not one of the seven legal encodings

Behaviour:
- Physical map:
  - P0-P15: USR/SYS r0-r15
  - P16-P22: FIQ r8-r14
  - P23-24: SVC r13/r14
  - P25-26: ABT r13/r14
  - P27-28: IRQ r13/r14
  - P29-30: UND r13/r14
  - r15 is always P15. Unbanked indices map to P0-P15.
- An illegal mode maps as USR and sets mode_err on the next cycle. user_bank=1 forces the USR map.
- Mapping is combinational from mode, user_bank and address each cycle. There are no cross-cycle mode-change hazards: a mode change takes effect for accesses in the same cycle.
- Reads: rd_addr sampled at posedge N appears on rd_data after posedge N (1-cycle latency). Ports are fully independent; any port may read any index.
- Writes: take effect at posedge.
  - Different physical targets: both writes commit.
  - Same physical target: wr1 wins.
  - A write is ignored while ready=0.
- Bypass (BYPASS=1): if a write commits at posedge N to the physical register a read port addresses at N, that port gets the write data, using the same wr1-over-wr0 priority. With BYPASS=0 the port gets the pre-write value.
- Clear FSM: states CLEAR and RUN.
  - reset=1 forces CLEAR with counter=0. An assertion mid-clear restarts from 0.
  - In CLEAR, P[counter] is written 0 each cycle and the counter increments. At counter=30 the FSM goes to RUN on the next edge, so CLEAR lasts 31 cycles after reset deasserts.
  - ready=0 in CLEAR and 1 in RUN. During CLEAR, rd_data returns 0.
  - CLEAR_ON_RESET=0: the FSM goes directly to RUN on the first edge with reset=0, with no register writes.
- Reset values: rd_data=0, ready=0, mode_err=0, counter=0.
- Asserting reset in RUN returns to CLEAR and clears the registers again (CLEAR_ON_RESET=1).

Test Plan:
- Reset for 2 cycles, release -> ready=0 for exactly 31 cycles, then 1. Read of r0..r15 in USR, plus r8-r14 in FIQ and r13/r14 in SVC/ABT/IRQ/UND -> all 0.
- USR write r13=0x11111111; SVC write r13=0x22222222; FIQ write r8=0x33333333 -> USR r13=0x11111111, SVC r13=0x22222222, FIQ r8=0x33333333, USR r8 unchanged (0), IRQ r13=0.
- SVC mode, user_bank=1, write r14=0xCAFEF00D -> USR r14=0xCAFEF00D, SVC r14 unchanged.
- Same cycle: wr0 r5=0xAAAA, wr1 r5=0xBBBB, read port 0 r5 -> rd_data0=0xBBBB next cycle (BYPASS=1); stored r5=0xBBBB. Repeat with BYPASS=0 -> old value returned, then 0xBBBB on the following read.
- mode=5'b10100 (illegal), write r13=0x5 -> mode_err=1 next cycle, USR r13=0x5.
- Reset asserted at clear counter 10 -> counter restarts, ready stays 0 for 31 more cycles. A write attempted during CLEAR is not stored.
